// File: rtl/r5p_rvmodel_pkg.sv
// Register map and decode helper for the RISC-V test-model control peripheral.
package r5p_rvmodel_pkg;

  localparam logic [5:0] RVM_BEGIN   = 6'h00;
  localparam logic [5:0] RVM_END     = 6'h08;
  localparam logic [5:0] RVM_STATUS  = 6'h10;
  localparam logic [5:0] RVM_CONSOLE = 6'h18;
  localparam logic [5:0] RVM_CNT_LO  = 6'h20;
  localparam logic [5:0] RVM_CNT_HI  = 6'h24;

  localparam int unsigned RVM_STATUS_HALT    = 0;
  localparam int unsigned RVM_STATUS_TIMEOUT = 1;

  typedef enum logic [2:0] {
    RegBegin,
    RegEnd,
    RegStatus,
    RegConsole,
    RegCntLo,
    RegCntHi,
    RegNone
  } rvm_reg_e;

  // Map a 6-bit offset onto a register; anything unmapped is RegNone.
  function automatic rvm_reg_e rvm_decode(input logic [5:0] off);
    rvm_reg_e sel;
    case (off)
      RVM_BEGIN:   sel = RegBegin;
      RVM_END:     sel = RegEnd;
      RVM_STATUS:  sel = RegStatus;
      RVM_CONSOLE: sel = RegConsole;
      RVM_CNT_LO:  sel = RegCntLo;
      RVM_CNT_HI:  sel = RegCntHi;
      default:     sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/r5p_rvmodel_fifo.sv
// Byte-wide synchronous FIFO for the console stream. Push is dropped when
// full and pop is dropped when empty.
module r5p_rvmodel_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdat,
  input  logic          pop,
  output logic [7:0]    rdat,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   level
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (PW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdat    = mem[rptr];

  // Pointers and fill level; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push & ~do_pop)      level <= level + 1'b1;
      else if (~do_push & do_pop) level <= level - 1'b1;
    end
  end

  // Storage needs no reset; the level alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdat;
  end

endmodule

// File: rtl/r5p_rvmodel_ctl.sv
// Test-model control responder: signature bounds, halt, console FIFO,
// free-running cycle counter and optional timeout.
module r5p_rvmodel_ctl
  import r5p_rvmodel_pkg::*;
#(
  parameter int unsigned AW  = 22,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = DW/8,
  parameter int unsigned DLY = 1,
  parameter int unsigned CFD = 4,
  parameter int unsigned TMO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_vld,
  input  logic          bus_wen,
  input  logic [AW-1:0] bus_adr,
  input  logic [BW-1:0] bus_ben,
  input  logic [DW-1:0] bus_wdt,
  output logic [DW-1:0] bus_rdt,
  output logic          bus_err,
  output logic          bus_rdy,
  output logic          con_vld,
  output logic [7:0]    con_dat,
  input  logic          con_rdy,
  output logic [DW-1:0] data_begin,
  output logic [DW-1:0] data_end,
  output logic          halt,
  output logic          timeout,
  output logic [63:0]   cnt
);

  localparam int unsigned LW = $clog2(CFD) + 1;

  rvm_reg_e      sel;
  logic          xfer;
  logic          wr_ok;
  logic          rd;
  logic          acc_err;
  logic          push_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] rdt_c;
  logic          unused_adr;

  assign unused_adr = ^bus_adr[AW-1:6];

  assign sel      = rvm_decode(bus_adr[5:0]);
  assign push_req = bus_wen & (sel == RegConsole) & bus_ben[0];
  // Full is judged before any same-cycle pop: no pass-through.
  assign bus_rdy  = ~(push_req & fifo_full);
  assign xfer     = bus_vld & bus_rdy;
  assign acc_err  = (sel == RegNone) | (bus_wen & ((sel == RegCntLo) | (sel == RegCntHi)));
  assign wr_ok    = xfer & bus_wen & ~acc_err;
  assign rd       = xfer & ~bus_wen;

  r5p_rvmodel_fifo #(
    .DEPTH (CFD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_ok & push_req),
    .wdat  (bus_wdt[7:0]),
    .pop   (con_rdy),
    .rdat  (con_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign con_vld = ~fifo_empty;

  // Read data mux; unmapped offsets read as zero.
  always_comb begin
    rdt_c = '0;
    unique case (sel)
      RegBegin:   rdt_c = data_begin;
      RegEnd:     rdt_c = data_end;
      RegStatus: begin
        rdt_c[RVM_STATUS_HALT]    = halt;
        rdt_c[RVM_STATUS_TIMEOUT] = timeout;
      end
      RegConsole: rdt_c = DW'(fifo_level);
      RegCntLo:   rdt_c = cnt[31:0];
      RegCntHi:   rdt_c = cnt[63:32];
      default:    rdt_c = '0;
    endcase
  end

  // Signature bounds with per-byte enables, and the sticky halt request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_begin <= '0;
      data_end   <= '0;
      halt       <= 1'b0;
    end else if (wr_ok) begin
      for (int unsigned i = 0; i < BW; i++) begin
        if (bus_ben[i] && sel == RegBegin) data_begin[8*i +: 8] <= bus_wdt[8*i +: 8];
        if (bus_ben[i] && sel == RegEnd)   data_end[8*i +: 8]   <= bus_wdt[8*i +: 8];
      end
      if (sel == RegStatus && bus_wdt[RVM_STATUS_HALT]) halt <= 1'b1;
    end
  end

  // Cycle counter runs until halt, wrapping at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (!halt) cnt <= cnt + 64'd1;
  end

  if (TMO != 0) begin : g_tmo
    // Sticky timeout, raised on the edge after the counter shows TMO-1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                         timeout <= 1'b0;
      else if (cnt == 64'(TMO - 1)) timeout <= 1'b1;
    end
  end else begin : g_no_tmo
    assign timeout = 1'b0;
  end

  if (DLY != 0) begin : g_dly
    // Registered response: rdata holds until the next read, err is a pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bus_rdt <= '0;
        bus_err <= 1'b0;
      end else begin
        bus_err <= xfer & acc_err;
        if (rd) bus_rdt <= rdt_c;
      end
    end
  end else begin : g_comb
    assign bus_rdt = rd ? rdt_c : '0;
    assign bus_err = xfer & acc_err;
  end

endmodule

// File: tb/tb_r5p_rvmodel_ctl.sv
// Self-checking bench for r5p_rvmodel_ctl: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level model.
module tb_r5p_rvmodel_ctl;

  localparam int unsigned AW  = 22;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int unsigned CFD = 4;
  localparam int unsigned TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bus_vld = 1'b0;
  logic          bus_wen = 1'b0;
  logic [AW-1:0] bus_adr = '0;
  logic [BW-1:0] bus_ben = '0;
  logic [DW-1:0] bus_wdt = '0;
  logic [DW-1:0] bus_rdt;
  logic          bus_err;
  logic          bus_rdy;
  logic          con_vld;
  logic [7:0]    con_dat;
  logic          con_rdy = 1'b0;
  logic [DW-1:0] data_begin;
  logic [DW-1:0] data_end;
  logic          halt;
  logic          timeout;
  logic [63:0]   cnt;

  int total = 0;
  int bad   = 0;

  r5p_rvmodel_ctl #(
    .AW  (AW),
    .DW  (DW),
    .BW  (BW),
    .DLY (1),
    .CFD (CFD),
    .TMO (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_vld    (bus_vld),
    .bus_wen    (bus_wen),
    .bus_adr    (bus_adr),
    .bus_ben    (bus_ben),
    .bus_wdt    (bus_wdt),
    .bus_rdt    (bus_rdt),
    .bus_err    (bus_err),
    .bus_rdy    (bus_rdy),
    .con_vld    (con_vld),
    .con_dat    (con_dat),
    .con_rdy    (con_rdy),
    .data_begin (data_begin),
    .data_end   (data_end),
    .halt       (halt),
    .timeout    (timeout),
    .cnt        (cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_begin, m_end, m_rdt;
  logic        m_halt, m_tmo, m_err;
  logic [63:0] m_cnt;
  logic [7:0]  m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_begin = '0; m_end = '0; m_rdt = '0;
    m_halt = 1'b0; m_tmo = 1'b0; m_err = 1'b0; m_cnt = '0;
    m_q.delete();
  endtask

  function automatic bit m_rdy();
    return !(bus_wen && bus_adr[5:0] == 6'h18 && bus_ben[0] && m_q.size() == CFD);
  endfunction

  // Apply one clock edge of behaviour to the model, using the current inputs.
  task automatic model_update();
    logic [5:0]  off;
    logic [31:0] rv;
    bit          xfer, e, pop;
    if (rst) begin
      model_reset();
      return;
    end
    off  = bus_adr[5:0];
    xfer = bus_vld && m_rdy();
    e    = !(off inside {6'h00, 6'h08, 6'h10, 6'h18, 6'h20, 6'h24}) ||
           (bus_wen && (off inside {6'h20, 6'h24}));
    case (off)
      6'h00:   rv = m_begin;
      6'h08:   rv = m_end;
      6'h10:   rv = {30'b0, m_tmo, m_halt};
      6'h18:   rv = 32'(m_q.size());
      6'h20:   rv = m_cnt[31:0];
      6'h24:   rv = m_cnt[63:32];
      default: rv = '0;
    endcase
    pop   = (m_q.size() > 0) && con_rdy;
    m_err = xfer && e;
    if (xfer && !bus_wen) m_rdt = rv;
    if (m_cnt == 64'(TMO - 1)) m_tmo = 1'b1;
    if (!m_halt) m_cnt = m_cnt + 1;
    if (pop) void'(m_q.pop_front());
    if (xfer && bus_wen && !e) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_ben[i] && off == 6'h00) m_begin[8*i +: 8] = bus_wdt[8*i +: 8];
        if (bus_ben[i] && off == 6'h08) m_end[8*i +: 8]   = bus_wdt[8*i +: 8];
      end
      if (off == 6'h10 && bus_wdt[0]) m_halt = 1'b1;
      if (off == 6'h18 && bus_ben[0]) m_q.push_back(bus_wdt[7:0]);
    end
  endtask

  task automatic compare_all();
    check("rdy", 64'(bus_rdy), 64'(m_rdy()));
    check("con_vld", 64'(con_vld), 64'(m_q.size() != 0));
    if (m_q.size() != 0) check("con_dat", 64'(con_dat), 64'(m_q[0]));
    check("data_begin", 64'(data_begin), 64'(m_begin));
    check("data_end", 64'(data_end), 64'(m_end));
    check("halt", 64'(halt), 64'(m_halt));
    check("timeout", 64'(timeout), 64'(m_tmo));
    check("cnt", cnt, m_cnt);
    check("rdt", 64'(bus_rdt), 64'(m_rdt));
    check("err", 64'(bus_err), 64'(m_err));
  endtask

  // Compare mid-cycle, then take the edge; returns at posedge+1.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic bus_write(input logic [5:0] off, input logic [3:0] ben, input logic [31:0] wdt);
    bit done = 0;
    bus_vld = 1; bus_wen = 1; bus_adr = AW'(off); bus_ben = ben; bus_wdt = wdt;
    for (int i = 0; i < 50 && !done; i++) begin
      done = m_rdy();
      step();
    end
    if (!done) check("write_timeout", 64'(done), 64'd1);
    bus_vld = 0; bus_wen = 0;
  endtask

  task automatic bus_read(input logic [5:0] off);
    bus_vld = 1; bus_wen = 0; bus_adr = AW'(off); bus_ben = '1;
    step();
    bus_vld = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    #2;
    rst = 0;
  endtask

  logic [7:0] got[$];
  int         acc_at;
  logic [5:0] offs [10] = '{6'h00, 6'h08, 6'h10, 6'h18, 6'h18, 6'h18, 6'h20, 6'h24, 6'h30, 6'h04};

  initial begin
    model_reset();
    #1 rst = 1;
    #1;
    check("reset_halt", 64'(halt), 64'd0);
    check("reset_cnt", cnt, 64'd0);
    check("reset_con_vld", 64'(con_vld), 64'd0);
    check("reset_rdt", 64'(bus_rdt), 64'd0);
    check("reset_err", 64'(bus_err), 64'd0);
    check("reset_begin", 64'(data_begin), 64'd0);
    @(posedge clk); #1;
    rst = 0;

    // Timeout: rises exactly 100 cycles after reset release.
    repeat (99) step();
    check("tmo_before", 64'(timeout), 64'd0);
    check("cnt_99", cnt, 64'd99);
    step();
    check("tmo_after", 64'(timeout), 64'd1);
    check("cnt_100", cnt, 64'd100);
    bus_read(6'h10);
    check("status_tmo", 64'(bus_rdt), 64'h2);

    // Signature bounds.
    bus_write(6'h00, 4'hF, 32'h1000_0200);
    bus_write(6'h08, 4'hF, 32'h1000_021C);
    bus_read(6'h00);
    check("rd_begin", 64'(bus_rdt), 64'h1000_0200);
    check("rd_begin_err", 64'(bus_err), 64'd0);
    bus_read(6'h08);
    check("rd_end", 64'(bus_rdt), 64'h1000_021C);
    check("out_end", 64'(data_end), 64'h1000_021C);
    bus_write(6'h00, 4'hF, 32'hAABB_CCDD);
    bus_write(6'h00, 4'b0101, 32'h1122_3344);
    check("ben_merge", 64'(data_begin), 64'hAA22_CC44);

    // Halt freezes the counter at N+1.
    do_reset();
    repeat (5) step();
    check("cnt_n", cnt, 64'd5);
    bus_write(6'h10, 4'hF, 32'h1);
    check("halt_set", 64'(halt), 64'd1);
    check("cnt_n1", cnt, 64'd6);
    repeat (10) step();
    check("cnt_frozen", cnt, 64'd6);
    bus_read(6'h10);
    check("status_halt", 64'(bus_rdt), 64'h1);

    // Console back-pressure and ordering.
    con_rdy = 0;
    for (int i = 0; i < 4; i++) bus_write(6'h18, 4'h1, 32'(8'h41 + i));
    bus_vld = 1; bus_wen = 1; bus_adr = AW'(6'h18); bus_ben = 4'h1; bus_wdt = 32'h45;
    for (int i = 0; i < 3; i++) begin
      check("full_rdy", 64'(bus_rdy), 64'd0);
      step();
    end
    con_rdy = 1;
    acc_at = -1;
    got.delete();
    for (int it = 0; it < 20; it++) begin
      if (con_vld) got.push_back(con_dat);
      if (bus_vld && bus_rdy && acc_at < 0) acc_at = it;
      step();
      if (acc_at == it) begin bus_vld = 0; bus_wen = 0; end
    end
    if (bus_vld) begin bus_vld = 0; bus_wen = 0; end
    check("fifth_accept_cycle", 64'(acc_at), 64'd1);
    check("con_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size() && i < 5; i++) check("con_order", 64'(got[i]), 64'(8'h41 + i));

    // Error responses.
    bus_read(6'h30);
    check("err_bad_off", 64'(bus_err), 64'd1);
    step();
    check("err_pulse", 64'(bus_err), 64'd0);
    bus_write(6'h20, 4'hF, 32'h1234_5678);
    check("err_ro", 64'(bus_err), 64'd1);
    step();
    check("err_ro_pulse", 64'(bus_err), 64'd0);

    // Reset during console drain.
    con_rdy = 0;
    for (int i = 0; i < 3; i++) bus_write(6'h18, 4'h1, 32'(8'h60 + i));
    con_rdy = 1;
    step();
    rst = 1;
    model_reset();
    #1;
    check("rst_con_vld", 64'(con_vld), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_cnt", cnt, 64'd0);
    check("rst_begin", 64'(data_begin), 64'd0);
    check("rst_rdt", 64'(bus_rdt), 64'd0);
    #1 rst = 0;

    // Randomized traffic in chunks separated by resets.
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 500; n++) begin
        bus_vld = 1'($urandom_range(0, 1));
        bus_wen = 1'($urandom_range(0, 1));
        bus_adr = {16'($urandom), offs[$urandom_range(0, 9)]};
        bus_ben = 4'($urandom);
        bus_wdt = $urandom;
        if (bus_adr[5:0] == 6'h10) bus_wdt[0] = ($urandom_range(0, 15) == 0);
        con_rdy = ($urandom_range(0, 3) != 0);
        step();
      end
      bus_vld = 0;
      do_reset();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r5p_rvmodel_ctl.md
# r5p_rvmodel_ctl

Synthesizable TCB responder that implements the RISC-V compliance/test-model control peripheral on the shared r5p system bus. It sits behind the load/store address decoder next to data memory. It captures signature begin/end addresses and the halt request, streams console bytes out through a small FIFO, and provides a free-running cycle counter with an optional timeout. It is the bus-responder counterpart of the r5p_mouse initiator port.

## Interface
- `AW`, 22, bus address width
- `DW`, 32, bus data width (only 32 supported)
- `BW`, DW/8, byte-enable width
- `DLY`, 1, read response latency in cycles (0 or 1)
- `CFD`, 4, console FIFO depth (power of 2, ≥2)
- `TMO`, 0, timeout in cycles; 0 disables timeout
- `clk` in 1 clock
- `rst` in 1 reset, asynchronous, active-high
- `bus_vld` in 1 request valid
- `bus_wen` in 1 write enable
- `bus_adr` in AW byte address
- `bus_ben` in BW byte enables
- `bus_wdt` in DW write data
- `bus_rdt` out DW read data
- `bus_err` out 1 error response
- `bus_rdy` out 1 request ready
- `con_vld` out 1 console byte valid
- `con_dat` out 8 console byte
- `con_rdy` in 1 console sink ready
- `data_begin` out DW signature start address
- `data_end` out DW signature end address
- `halt` out 1 halt request, sticky
- `timeout` out 1 timeout flag, sticky
- `cnt` out 64 cycle counter

## Operation
- A transfer occurs on a cycle with `bus_vld & bus_rdy`. Decode uses `bus_adr[5:0]`; upper bits are ignored.
- Register map:
  - 0x00 BEGIN (RW, per-byte `ben`)
  - 0x08 END (RW, per-byte `ben`)
  - 0x10 STATUS: write bit0=1 sets `halt`, bit0=0 is ignored; read returns {30'b0, timeout, halt}
  - 0x18 CONSOLE: write with `ben[0]` pushes `wdt[7:0]`, write without `ben[0]` is accepted with no push; read returns FIFO level in bits [$clog2(CFD):0]
  - 0x20 CNT_LO (RO)
  - 0x24 CNT_HI (RO)
- Any other offset: transfer is accepted, `bus_err=1` in the response, no state change. Writes to RO registers also return err.
- `bus_rdy = ~(bus_wen & adr==0x18 & ben[0] & fifo_full)`. Full is evaluated before a same-cycle pop, so there is no pass-through.
- Console FIFO: push on accepted CONSOLE write, pop on `con_vld & con_rdy`. `con_vld = ~empty`, `con_dat` = head. Simultaneous push and pop when non-full and non-empty leaves the level unchanged.
- Counter increments by 1 each cycle while `halt==0`, freezes once `halt` is set, and wraps modulo 2^64.
- Timeout: when TMO≠0 and `cnt==TMO-1`, `timeout` sets on the next edge and stays set. It is independent of halt.

## Timing
- Reset values: `data_begin=0`, `data_end=0`, `halt=0`, `timeout=0`, `cnt=0`, FIFO empty, `con_vld=0`, `bus_rdt=0`, `bus_err=0`.
- DLY=1: `bus_rdt` and `bus_err` are registered and valid the cycle after the transfer. `bus_rdt` holds its value until the next read transfer. `bus_err` is a one-cycle pulse.
- DLY=0: `bus_rdt`/`bus_err` are combinational in the transfer cycle.
- Register writes take effect at the transfer edge. A read in the following cycle returns the new value.
- CNT_LO/CNT_HI reads sample `cnt` at the transfer cycle. No hi/lo snapshot is provided.
- An accepted write to CONSOLE makes `con_vld=1` the next cycle when the FIFO was empty.
- Asserting `rst` mid-operation clears everything immediately, including FIFO contents and any pending response.

## Structure
- Package `r5p_rvmodel_pkg`: register offset constants (`RVM_BEGIN`, `RVM_END`, `RVM_STATUS`, `RVM_CONSOLE`, `RVM_CNT_LO`, `RVM_CNT_HI`) and the status bit indices.
- Sub-module `r5p_rvmodel_fifo`: synchronous FIFO (width 8, depth CFD) with `full`, `empty` and `level` outputs.

## Test plan
- Write BEGIN=0x1000_0200 with ben=4'b1111, write END=0x1000_021C, then read both → rdt=0x1000_0200 and 0x1000_021C one cycle after each read, err=0, outputs match.
- Write BEGIN=0xAABB_CCDD, then a write of 0x1122_3344 with ben=4'b0101 → BEGIN=0xAA22_CC44.
- With `con_rdy=0`, push 5 bytes 0x41..0x45 (CFD=4) → first 4 accepted. The 5th write holds `bus_rdy=0`. Raise `con_rdy`: bytes appear in order 0x41..0x45, and the 5th write is accepted the cycle after the first pop.
- Write STATUS=1 at cnt=N → `halt=1` next cycle. `cnt` stays at N+1 thereafter. STATUS read returns 0x1.
- TMO=100, no halt → `timeout` rises exactly 100 cycles after reset release and stays high. STATUS read returns 0x2.
- Read offset 0x30 and write CNT_LO → `bus_err=1` for one cycle each, no register changes. Then assert rst mid-FIFO-drain → `con_vld=0` immediately, all outputs at reset values.
